// File: rtl/incr_pipe_sched.sv
// Shared add-one pipeline: round-robin admits one operand per cycle from NREQ requesters, DEPTH stages each add 1.
// Latency: operand accepted at edge t is presented on resp_* after edge t+DEPTH-1 (no stalls).
// Backpressure: resp_valid & ~resp_ready freezes every stage, the RR pointer and drops all req_ready bits.
// Optional: define INCR_PIPE_SCHED_STATS_EN to add the saturating done_cnt completion counter port.
module incr_pipe_sched #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 5,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_data,
    input  logic                  resp_ready,
    output logic                  busy
`ifdef INCR_PIPE_SCHED_STATS_EN
    ,
    output logic [31:0]           done_cnt
`endif
);

    logic [DEPTH-1:0] stage_vld;
    logic [WIDTH-1:0] stage_dat [DEPTH];
    logic [IDW-1:0]   stage_id  [DEPTH];

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_nxt;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             accept;
    logic             stall;
    logic [WIDTH-1:0] grant_dat;
    int               cand;

    assign stall  = stage_vld[DEPTH-1] & ~resp_ready;
    assign accept = grant_any & ~stall;

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(cand);
            end
        end
    end

    // One-hot ready, suppressed during stall and while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_dat = req_data[int'(grant_idx)*WIDTH +: WIDTH];
    assign ptr_nxt   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);

    // Pointer moves past the winner only when an operand is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr_nxt;
        end
    end

    // Pipeline stages: advance together when not stalled; data/id only load behind a valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_dat[k] <= '0;
                stage_id[k]  <= '0;
            end
        end else if (!stall) begin
            stage_vld[0] <= accept;
            if (accept) begin
                stage_dat[0] <= grant_dat + WIDTH'(1);
                stage_id[0]  <= grant_idx;
            end
            for (int k = 1; k < DEPTH; k++) begin
                stage_vld[k] <= stage_vld[k-1];
                if (stage_vld[k-1]) begin
                    stage_dat[k] <= stage_dat[k-1] + WIDTH'(1);
                    stage_id[k]  <= stage_id[k-1];
                end
            end
        end
    end

    assign resp_valid = stage_vld[DEPTH-1];
    assign resp_id    = stage_id[DEPTH-1];
    assign resp_data  = stage_dat[DEPTH-1];
    assign busy       = |stage_vld;

`ifdef INCR_PIPE_SCHED_STATS_EN
    // Completed-result counter, sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (resp_valid && resp_ready && (done_cnt != 32'hFFFF_FFFF)) begin
            done_cnt <= done_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_incr_pipe_sched.sv
// Bench for incr_pipe_sched (NREQ=4, WIDTH=32, DEPTH=5).
// Inputs driven on the falling edge, outputs sampled 1 ns later.
// Directed table vectors plus stream/stall, mid-flight reset and counter sequences.
module tb_incr_pipe_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         resp_valid;
    logic [1:0]   resp_id;
    logic [31:0]  resp_data;
    logic         resp_ready;
    logic         busy;
`ifdef INCR_PIPE_SCHED_STATS_EN
    logic [31:0]  done_cnt;
`endif

    int checks = 0;
    int errors = 0;

    incr_pipe_sched #(.NREQ(4), .WIDTH(32), .DEPTH(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy)
`ifdef INCR_PIPE_SCHED_STATS_EN
        ,
        .done_cnt   (done_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   rv;
        logic [127:0] rd;
        logic         rr;
        logic [3:0]   ex_rdy;
        logic         ex_vld;
        logic [1:0]   ex_id;
        logic [31:0]  ex_dat;
        logic         ex_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] a3, input logic [31:0] a2,
                                        input logic [31:0] a1, input logic [31:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    task automatic add(input logic [3:0] rv, input logic [127:0] rd, input logic rr,
                       input logic [3:0] rdy, input logic vld, input logic [1:0] id,
                       input logic [31:0] dat, input logic bsy);
        vec_t v;
        v.rv = rv; v.rd = rd; v.rr = rr; v.ex_rdy = rdy;
        v.ex_vld = vld; v.ex_id = id; v.ex_dat = dat; v.ex_busy = bsy;
        tbl.push_back(v);
    endtask

    // Stream n operands from requester rq; resp_ready low for stream cycles 6..8.
    task automatic run_stream(input int n, input int rq);
        int          sent;
        int          got;
        int          stalls;
        logic        prev_stall;
        logic [1:0]  prev_id;
        logic [31:0] prev_dat;
        sent = 0; got = 0; stalls = 0;
        prev_stall = 1'b0; prev_id = '0; prev_dat = '0;
        for (int c = 0; c < 100 && got < n; c++) begin
            @(negedge clk);
            req_valid = '0;
            if (sent < n) req_valid[rq] = 1'b1;
            req_data = '0;
            req_data[rq*32 +: 32] = 32'h1000 + 32'(sent);
            resp_ready = !(c >= 6 && c <= 8);
            #1;
            if (prev_stall) begin
                chk("hold_vld", 64'(resp_valid), 64'd1);
                chk("hold_id",  64'(resp_id),    64'(prev_id));
                chk("hold_dat", 64'(resp_data),  64'(prev_dat));
            end
            prev_stall = resp_valid && !resp_ready;
            if (prev_stall) begin
                stalls++;
                chk("stall_rdy", 64'(req_ready), 64'd0);
            end else if (sent < n) begin
                chk("stream_grant", 64'(req_ready), 64'(4'b0001 << rq));
            end
            prev_id  = resp_id;
            prev_dat = resp_data;
            if (req_valid[rq] && req_ready[rq]) sent++;
            if (resp_valid && resp_ready) begin
                chk("stream_id",  64'(resp_id),   64'(rq));
                chk("stream_dat", 64'(resp_data), 64'(32'h1000 + 32'(got) + 32'd5));
                got++;
            end
        end
        chk("stream_count",  64'(got),    64'(n));
        chk("stream_stalls", 64'(stalls), 64'd3);
        req_valid  = '0;
        resp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Single op from requester 0, then idle; rr low while nothing is emitted.
        add(4'b0001, mk(0, 0, 0, 32'h1234), 1'b1, 4'b0001, 1'b0, 2'd0, 32'h0, 1'b0);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
        add(4'b0000, '0, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
        add(4'b0000, '0, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h1239, 1'b1);
        // All four valid; pointer is 1 after the first grant.
        add(4'b1111, mk(32'h40, 32'h30, 32'h20, 32'h10), 1'b1, 4'b0010, 1'b0, 2'd0, 32'h0, 1'b0);
        add(4'b1111, mk(32'h40, 32'h30, 32'h20, 32'h10), 1'b0, 4'b0100, 1'b0, 2'd0, 32'h0, 1'b1);
        add(4'b1111, mk(32'h40, 32'h30, 32'h20, 32'h10), 1'b0, 4'b1000, 1'b0, 2'd0, 32'h0, 1'b1);
        add(4'b1111, mk(32'h40, 32'h30, 32'h20, 32'h10), 1'b1, 4'b0001, 1'b0, 2'd0, 32'h0, 1'b1);
        add(4'b1111, mk(32'h40, 32'h30, 32'h20, 32'h10), 1'b1, 4'b0010, 1'b0, 2'd0, 32'h0, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h25, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b1, 2'd2, 32'h35, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b1, 2'd3, 32'h45, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h15, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h25, 1'b1);
        // Wrap-around arithmetic on requesters 2 and 3.
        add(4'b0100, mk(0, 32'hFFFF_FFFE, 0, 0), 1'b1, 4'b0100, 1'b0, 2'd0, 32'h0, 1'b0);
        add(4'b1000, mk(32'hFFFF_FFFF, 0, 0, 0), 1'b1, 4'b1000, 1'b0, 2'd0, 32'h0, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b1, 2'd2, 32'h0000_0003, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b1, 2'd3, 32'h0000_0004, 1'b1);
        add(4'b0000, '0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0);

        // Reset state, with requests present.
        rst_n = 1'b0; req_valid = 4'hF; req_data = '0; resp_ready = 1'b1;
        #2;
        chk("rst_rdy",  64'(req_ready),  64'd0);
        chk("rst_vld",  64'(resp_valid), 64'd0);
        chk("rst_id",   64'(resp_id),    64'd0);
        chk("rst_dat",  64'(resp_data),  64'd0);
        chk("rst_busy", 64'(busy),       64'd0);
`ifdef INCR_PIPE_SCHED_STATS_EN
        chk("rst_done_cnt", 64'(done_cnt), 64'd0);
`endif
        @(negedge clk); req_valid = '0;
        @(negedge clk); rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            req_valid  = tbl[i].rv;
            req_data   = tbl[i].rd;
            resp_ready = tbl[i].rr;
            #1;
            chk($sformatf("row%0d_rdy", i),  64'(req_ready),  64'(tbl[i].ex_rdy));
            chk($sformatf("row%0d_vld", i),  64'(resp_valid), 64'(tbl[i].ex_vld));
            chk($sformatf("row%0d_busy", i), 64'(busy),       64'(tbl[i].ex_busy));
            if (tbl[i].ex_vld) begin
                chk($sformatf("row%0d_id", i),  64'(resp_id),   64'(tbl[i].ex_id));
                chk($sformatf("row%0d_dat", i), 64'(resp_data), 64'(tbl[i].ex_dat));
            end
        end

        // Backpressure mid-stream.
        run_stream(8, 2);

        // Reset with three operands in flight.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'b0001;
            req_data  = mk(0, 0, 0, 32'h77);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("mid_rst_vld",  64'(resp_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy),       64'd0);
        chk("mid_rst_rdy",  64'(req_ready),  64'd0);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_idle", 64'({resp_valid, busy}), 64'd0);
        end
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("ptr_restart", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = '0;

        // Completion counter over a stalled stream of 10.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2_busy", 64'(busy), 64'd0);
`ifdef INCR_PIPE_SCHED_STATS_EN
        chk("rst2_done_cnt", 64'(done_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_stream(10, 1);
        @(negedge clk);
        #1;
        chk("final_idle", 64'({resp_valid, busy}), 64'd0);
`ifdef INCR_PIPE_SCHED_STATS_EN
        chk("done_cnt_10", 64'(done_cnt), 64'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
